// File: rtl/pipe_reg_if.sv
// Handshake bundle for pipe_reg: upstream (in_*) and downstream (out_*) channels.
// A beat moves on a channel at the falling clock edge where valid && ready are both 1;
// valid never depends on ready, and data is held stable while valid=1 and ready=0.
interface pipe_reg_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_reg.sv
// Elastic DEPTH-stage register pipeline with bubble collapse, flush and negedge updates.
// Optional occupancy counter port "count" is built when PIPE_REG_COUNT_EN is defined.
module pipe_reg #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  pipe_reg_if.slave bus
`ifdef PIPE_REG_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];

  // A stage may load when it is empty or the stage after it is moving,
  // so bubbles are squeezed out and ready ripples back from out_ready.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = !v[DEPTH-1] || bus.out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = !v[i] || adv[i+1];
    end
  end

  always_comb begin
    src_v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      src_d[i] = '0;
    end
    src_v[0] = bus.in_valid;
    src_d[0] = bus.in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  assign bus.in_ready  = adv[0] && reset && !clear;
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];

  // Data registers only capture real beats; a bubble leaves the old data in place.
  always_ff @(negedge clk) begin
    if (!reset || clear) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i]) begin
          v[i] <= src_v[i];
          if (src_v[i]) begin
            d[i] <= src_d[i];
          end
        end
      end
    end
  end

`ifdef PIPE_REG_COUNT_EN
  logic in_fire;
  logic out_fire;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  always_ff @(negedge clk) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (in_fire && !out_fire) begin
      count <= count + 1'b1;
    end else if (out_fire && !in_fire) begin
      count <= count - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg: directed scenarios on DEPTH=2/1/4 instances
// plus randomized traffic against a queue-based occupancy/ordering model.
module tb_pipe_reg;

  logic clk;
  logic reset;
  logic clear;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];

  pipe_reg_if #(.WIDTH(4)) b2 ();
  pipe_reg_if #(.WIDTH(4)) b1 ();
  pipe_reg_if #(.WIDTH(8)) b4 ();

`ifdef PIPE_REG_COUNT_EN
  logic [1:0] cnt2;
  logic       cnt1;
  logic [2:0] cnt4;
`endif

  pipe_reg #(.WIDTH(4), .DEPTH(2)) u2 (
    .clk(clk), .reset(reset), .clear(clear), .bus(b2)
`ifdef PIPE_REG_COUNT_EN
    , .count(cnt2)
`endif
  );

  pipe_reg #(.WIDTH(4), .DEPTH(1)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .bus(b1)
`ifdef PIPE_REG_COUNT_EN
    , .count(cnt1)
`endif
  );

  pipe_reg #(.WIDTH(8), .DEPTH(4)) u4 (
    .clk(clk), .reset(reset), .clear(clear), .bus(b4)
`ifdef PIPE_REG_COUNT_EN
    , .count(cnt4)
`endif
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_all();
    b2.in_valid = 1'b0; b2.in_data = '0; b2.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
    b4.in_valid = 1'b0; b4.in_data = '0; b4.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear = 1'b0;
    idle_all();
    b2.in_valid = 1'b1; b2.in_data = 4'h3; b2.out_ready = 1'b1;
    b1.in_valid = 1'b1; b1.in_data = 4'h3; b1.out_ready = 1'b1;
    repeat (2) begin
      #1;
      n_checks++;
      if (b2.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", b2.in_ready);
      else n_pass++;
      cycle();
      n_checks++;
      if (b2.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", b2.out_valid);
      else n_pass++;
      n_checks++;
      if (b2.out_data !== 4'h0) $display("FAIL reset_out_data: got %h want 0", b2.out_data);
      else n_pass++;
      n_checks++;
      if (b1.out_valid !== 1'b0) $display("FAIL reset_d1_out_valid: got %b want 0", b1.out_valid);
      else n_pass++;
    end
    idle_all();
    reset = 1'b1;
    #1;
    n_checks++;
    if (b2.in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", b2.in_ready);
    else n_pass++;
    n_checks++;
    if (b4.in_ready !== 1'b1) $display("FAIL release_d4_in_ready: got %b want 1", b4.in_ready);
    else n_pass++;
`ifdef PIPE_REG_COUNT_EN
    n_checks++;
    if (cnt2 !== 2'd0) $display("FAIL reset_count: got %0d want 0", cnt2);
    else n_pass++;
`endif
    cycle();
  endtask

  task automatic test_stream();
    b2.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      b2.in_valid = (c < 4);
      b2.in_data  = 4'(c + 1);
      #1;
      if (c < 4) begin
        n_checks++;
        if (b2.in_ready !== 1'b1) $display("FAIL stream_in_ready c=%0d: got %b want 1", c, b2.in_ready);
        else n_pass++;
      end
      cycle();
      n_checks++;
      if (b2.out_valid !== (c >= 1 && c <= 4))
        $display("FAIL stream_out_valid c=%0d: got %b want %b", c, b2.out_valid, (c >= 1 && c <= 4));
      else n_pass++;
      if (c >= 1 && c <= 4) begin
        n_checks++;
        if (b2.out_data !== 4'(c)) $display("FAIL stream_out_data c=%0d: got %h want %h", c, b2.out_data, 4'(c));
        else n_pass++;
      end
    end
    idle_all();
  endtask

  task automatic test_depth1();
    b1.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      b1.in_valid = (c < 4);
      b1.in_data  = 4'(c + 1);
      cycle();
      n_checks++;
      if (b1.out_valid !== (c <= 3)) $display("FAIL d1_out_valid c=%0d: got %b want %b", c, b1.out_valid, (c <= 3));
      else n_pass++;
      if (c <= 3) begin
        n_checks++;
        if (b1.out_data !== 4'(c + 1)) $display("FAIL d1_out_data c=%0d: got %h want %h", c, b1.out_data, 4'(c + 1));
        else n_pass++;
      end
    end
    idle_all();
  endtask

  task automatic test_stall();
    logic [3:0] send [3];
    int si;
    logic in_acc;
    send[0] = 4'h5; send[1] = 4'h6; send[2] = 4'h7;
    exp_q.delete();
    exp_q.push_back(8'h05); exp_q.push_back(8'h06); exp_q.push_back(8'h07);
    si = 0;
    for (int cyc = 0; cyc < 20 && (si < 3 || exp_q.size() != 0); cyc++) begin
      b2.out_ready = (cyc >= 5);
      b2.in_valid  = (si < 3);
      b2.in_data   = (si < 3) ? send[si] : 4'h0;
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        n_checks++;
        if (b2.in_ready !== 1'b0) $display("FAIL stall_in_ready cyc=%0d: got %b want 0", cyc, b2.in_ready);
        else n_pass++;
        n_checks++;
        if (b2.out_valid !== 1'b1 || b2.out_data !== 4'h5)
          $display("FAIL stall_hold cyc=%0d: got %b/%h want 1/5", cyc, b2.out_valid, b2.out_data);
        else n_pass++;
      end
      in_acc = b2.in_valid && b2.in_ready;
      if (b2.out_valid && b2.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL stall_extra_beat: got %h want none", b2.out_data);
        else if ({4'h0, b2.out_data} !== exp_q[0])
          $display("FAIL stall_order: got %h want %h", b2.out_data, exp_q[0]);
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      cycle();
      if (in_acc) si++;
    end
    n_checks++;
    if (exp_q.size() != 0 || si != 3) $display("FAIL stall_drain: got left=%0d sent=%0d want 0/3", exp_q.size(), si);
    else n_pass++;
    idle_all();
  endtask

  task automatic test_clear();
    b2.out_ready = 1'b0;
    b2.in_valid = 1'b1; b2.in_data = 4'h9; cycle();
    b2.in_data = 4'hA; cycle();
    n_checks++;
    if (b2.out_valid !== 1'b1 || b2.out_data !== 4'h9)
      $display("FAIL clear_full: got %b/%h want 1/9", b2.out_valid, b2.out_data);
    else n_pass++;
    clear = 1'b1;
    b2.in_data = 4'hB;
    #1;
    n_checks++;
    if (b2.in_ready !== 1'b0) $display("FAIL clear_in_ready: got %b want 0", b2.in_ready);
    else n_pass++;
    cycle();
    clear = 1'b0;
    n_checks++;
    if (b2.out_valid !== 1'b0 || b2.out_data !== 4'h0)
      $display("FAIL clear_out: got %b/%h want 0/0", b2.out_valid, b2.out_data);
    else n_pass++;
`ifdef PIPE_REG_COUNT_EN
    n_checks++;
    if (cnt2 !== 2'd0) $display("FAIL clear_count: got %0d want 0", cnt2);
    else n_pass++;
`endif
    b2.in_valid = 1'b0;
    b2.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      n_checks++;
      if (b2.out_valid !== 1'b0) $display("FAIL clear_b_dropped c=%0d: got %b want 0", c, b2.out_valid);
      else n_pass++;
    end
    idle_all();
  endtask

  task automatic test_reset_clear();
    b2.in_valid = 1'b1; b2.in_data = 4'h3; cycle();
    b2.in_valid = 1'b0;
    reset = 1'b0;
    clear = 1'b1;
    #1;
    n_checks++;
    if (b2.in_ready !== 1'b0) $display("FAIL rstclr_in_ready: got %b want 0", b2.in_ready);
    else n_pass++;
    cycle();
    n_checks++;
    if (b2.out_valid !== 1'b0 || b2.out_data !== 4'h0)
      $display("FAIL rstclr_out: got %b/%h want 0/0", b2.out_valid, b2.out_data);
    else n_pass++;
    reset = 1'b1;
    clear = 1'b0;
    b2.out_ready = 1'b1;
    #1;
    n_checks++;
    if (b2.in_ready !== 1'b1) $display("FAIL rstclr_release: got %b want 1", b2.in_ready);
    else n_pass++;
    repeat (2) begin
      cycle();
      n_checks++;
      if (b2.out_valid !== 1'b0) $display("FAIL rstclr_empty: got %b want 0", b2.out_valid);
      else n_pass++;
    end
    idle_all();
  endtask

  task automatic test_count();
    logic [7:0] val;
    exp_q.delete();
    b4.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      val = 8'($urandom_range(0, 255));
      exp_q.push_back(val);
      b4.in_valid = 1'b1;
      b4.in_data = val;
      cycle();
    end
    b4.in_valid = 1'b0;
    cycle();
`ifdef PIPE_REG_COUNT_EN
    n_checks++;
    if (cnt4 !== 3'd3) $display("FAIL count_three: got %0d want 3", cnt4);
    else n_pass++;
`endif
    n_checks++;
    if (b4.out_valid !== 1'b1 || b4.out_data !== exp_q[0])
      $display("FAIL count_head: got %b/%h want 1/%h", b4.out_valid, b4.out_data, exp_q[0]);
    else n_pass++;
    val = 8'($urandom_range(0, 255));
    b4.in_valid = 1'b1;
    b4.in_data = val;
    b4.out_ready = 1'b1;
    #1;
    n_checks++;
    if (b4.in_ready !== 1'b1) $display("FAIL count_both_ready: got %b want 1", b4.in_ready);
    else n_pass++;
    void'(exp_q.pop_front());
    exp_q.push_back(val);
    cycle();
    b4.in_valid = 1'b0;
`ifdef PIPE_REG_COUNT_EN
    n_checks++;
    if (cnt4 !== 3'd3) $display("FAIL count_both: got %0d want 3", cnt4);
    else n_pass++;
`endif
    for (int c = 0; c < 12 && exp_q.size() != 0; c++) begin
      #1;
      if (b4.out_valid) begin
        n_checks++;
        if (b4.out_data !== exp_q[0]) $display("FAIL count_drain: got %h want %h", b4.out_data, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
      end
      cycle();
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL count_drain_left: got %0d want 0", exp_q.size());
    else n_pass++;
    idle_all();
  endtask

  // Model: a pipe of DEPTH slots is a FIFO of accepted-not-yet-consumed beats.
  task automatic test_random(input int sel);
    logic [7:0] mq[$];
    int depth;
    int dmax;
    logic iv, ordy, clr, ir, ov, exp_ir, stalled_prev;
    logic [7:0] id, od, held;
    int cn;
    depth = (sel == 0) ? 2 : 4;
    dmax  = (sel == 0) ? 15 : 255;
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    stalled_prev = 1'b0;
    held = '0;
    for (int n = 0; n < 300; n++) begin
      iv   = ($urandom_range(0, 3) != 0);
      id   = 8'($urandom_range(0, dmax));
      ordy = ($urandom_range(0, 2) != 0);
      clr  = ($urandom_range(0, 39) == 0);
      clear = clr;
      if (sel == 0) begin
        b2.in_valid = iv; b2.in_data = id[3:0]; b2.out_ready = ordy;
      end else begin
        b4.in_valid = iv; b4.in_data = id; b4.out_ready = ordy;
      end
      #1;
      if (sel == 0) begin
        ir = b2.in_ready; ov = b2.out_valid; od = {4'h0, b2.out_data};
      end else begin
        ir = b4.in_ready; ov = b4.out_valid; od = b4.out_data;
      end
      exp_ir = !clr && ((mq.size() < depth) || ordy);
      n_checks++;
      if (ir !== exp_ir) $display("FAIL rand%0d_in_ready n=%0d: got %b want %b", sel, n, ir, exp_ir);
      else n_pass++;
      if (mq.size() == 0) begin
        n_checks++;
        if (ov !== 1'b0) $display("FAIL rand%0d_empty n=%0d: got %b want 0", sel, n, ov);
        else n_pass++;
      end
      if (mq.size() == depth) begin
        n_checks++;
        if (ov !== 1'b1) $display("FAIL rand%0d_full n=%0d: got %b want 1", sel, n, ov);
        else n_pass++;
      end
      if (stalled_prev) begin
        n_checks++;
        if (ov !== 1'b1 || od !== held)
          $display("FAIL rand%0d_hold n=%0d: got %b/%h want 1/%h", sel, n, ov, od, held);
        else n_pass++;
      end
      if (ov && ordy && mq.size() != 0) begin
        n_checks++;
        if (od !== mq[0]) $display("FAIL rand%0d_data n=%0d: got %h want %h", sel, n, od, mq[0]);
        else n_pass++;
        void'(mq.pop_front());
      end
      if (iv && exp_ir) mq.push_back(id);
      if (clr) mq.delete();
      stalled_prev = ov && !ordy && !clr;
      held = od;
      cycle();
`ifdef PIPE_REG_COUNT_EN
      cn = (sel == 0) ? int'(cnt2) : int'(cnt4);
      n_checks++;
      if (cn != mq.size()) $display("FAIL rand%0d_count n=%0d: got %0d want %0d", sel, n, cn, mq.size());
      else n_pass++;
`else
      cn = 0;
`endif
    end
    clear = 1'b0;
    idle_all();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_stream();
    test_depth1();
    test_stall();
    test_clear();
    test_reset_clear();
    test_count();
    test_random(0);
    test_random(1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
